// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED bank pattern sequencer with handshake-loaded mode/speed
//
// Steps an LED bank through one of several animation patterns. A host loads
// mode, speed and a static pattern over a valid/ready handshake. run_en
// pauses and resumes the animation without losing the prescaler phase.
//
// Ports:
//   sys_clk     system clock
//   sys_nrst    asynchronous active-low reset
//   cfg_valid   host offers a configuration
//   cfg_ready   configuration accepted this cycle (low only while loading)
//   cfg_mode    pattern select (0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK, 4 FILL, 5 STATIC)
//   cfg_speed   step period = TICK_DIV >> cfg_speed
//   cfg_static  pattern shown in STATIC mode
//   run_en      1 = animate, 0 = freeze
//   cfg_err     one-cycle pulse when a reserved mode is offered
//   step        one-cycle pulse on every pattern update
//   led         LED drive, 1 = lit
module led_seq_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int LED_W    = 8
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_mode,
  input  logic [1:0]       cfg_speed,
  input  logic [LED_W-1:0] cfg_static,
  input  logic             run_en,
  output logic             cfg_err,
  output logic             step,
  output logic [LED_W-1:0] led
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [2:0] M_ROTL   = 3'd0;
  localparam logic [2:0] M_ROTR   = 3'd1;
  localparam logic [2:0] M_BOUNCE = 3'd2;
  localparam logic [2:0] M_BLINK  = 3'd3;
  localparam logic [2:0] M_FILL   = 3'd4;
  localparam logic [2:0] M_STATIC = 3'd5;

  localparam logic [LED_W-1:0] PAT_LSB = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] PAT_MSB = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t           state_q;
  logic [2:0]       mode_q;
  logic [1:0]       speed_q;
  logic [LED_W-1:0] static_q;
  logic [LED_W-1:0] led_q;
  logic [PW-1:0]    presc_q;
  logic             dir_q;       // 0 = moving toward MSB, 1 = toward LSB
  logic             cfg_ready_q;
  logic             cfg_err_q;
  logic             step_q;

  logic [LED_W-1:0] led_d;
  logic             dir_d;
  logic [LED_W-1:0] init_pat;
  logic [31:0]      period;
  logic             xfer;
  logic             xfer_ok;
  logic             tick;

  assign xfer    = cfg_valid && cfg_ready_q;
  assign xfer_ok = xfer && (cfg_mode <= M_STATIC);
  assign period  = 32'(TICK_DIV) >> speed_q;
  assign tick    = (32'(presc_q) == period - 32'd1);

  always_comb begin
    case (mode_q)
      M_ROTL, M_BOUNCE: init_pat = PAT_LSB;
      M_ROTR:           init_pat = PAT_MSB;
      M_STATIC:         init_pat = static_q;
      default:          init_pat = '0;
    endcase
  end

  // Next pattern for the current mode; the bounce direction flips on the
  // step that lands on an end LED so that LED is lit for exactly one step.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    case (mode_q)
      M_ROTL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
      M_ROTR: led_d = {led_q[0], led_q[LED_W-1:1]};
      M_BOUNCE: begin
        if (!dir_q) begin
          led_d = led_q << 1;
          if (led_d == PAT_MSB) dir_d = 1'b1;
        end else begin
          led_d = led_q >> 1;
          if (led_d == PAT_LSB) dir_d = 1'b0;
        end
      end
      M_BLINK: led_d = ~led_q;
      M_FILL:  led_d = (&led_q) ? '0 : {led_q[LED_W-2:0], 1'b1};
      default: led_d = led_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q     <= S_IDLE;
      mode_q      <= M_ROTL;
      speed_q     <= '0;
      static_q    <= '0;
      led_q       <= '0;
      presc_q     <= '0;
      dir_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      cfg_err_q   <= xfer && !xfer_ok;
      step_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      // An accepted configuration overrides any tick or run_en change.
      if (xfer_ok) begin
        mode_q      <= cfg_mode;
        speed_q     <= cfg_speed;
        static_q    <= cfg_static;
        state_q     <= S_LOAD;
        cfg_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: led_q <= '0;
          S_LOAD: begin
            led_q   <= init_pat;
            presc_q <= '0;
            dir_q   <= 1'b0;
            state_q <= run_en ? S_RUN : S_HOLD;
          end
          S_RUN: begin
            if (!run_en) begin
              state_q <= S_HOLD;
            end else if (tick) begin
              presc_q <= '0;
              if (mode_q != M_STATIC) begin
                led_q  <= led_d;
                dir_q  <= dir_d;
                step_q <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          default: begin
            if (run_en) state_q <= S_RUN;
          end
        endcase
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign step      = step_q;
  assign led       = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - self-checking bench for led_seq_ctrl
module tb_led_seq_ctrl;

  localparam int TD = 8;

  logic       sys_clk = 1'b0;
  logic       sys_nrst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_mode;
  logic [1:0] cfg_speed;
  logic [7:0] cfg_static;
  logic       run_en;
  logic       cfg_err;
  logic       step;
  logic [7:0] led;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  led_seq_ctrl #(.TICK_DIV(TD), .LED_W(8)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_speed(cfg_speed), .cfg_static(cfg_static),
    .run_en(run_en), .cfg_err(cfg_err), .step(step), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [1:0] s, input logic [7:0] st);
    cfg_mode = m; cfg_speed = s; cfg_static = st; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Cycles until the next step pulse, or -1 when none arrives within maxc.
  task automatic wait_step(input int maxc, output int gap);
    gap = 0;
    do begin
      cyc();
      gap++;
    end while (step !== 1'b1 && gap < maxc);
    if (step !== 1'b1) gap = -1;
  endtask

  task automatic test_reset();
    bit bad;
    tests_run++;
    if (led !== 8'h00 || cfg_ready !== 1'b1 || cfg_err !== 1'b0 || step !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: led=%h ready=%b err=%b step=%b, need 00 1 0 0", led, cfg_ready, cfg_err, step);
    end
    sys_nrst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (led !== 8'h00 || step !== 1'b0 || cfg_ready !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin fails++; $display("FAIL idle_quiet: led=%h step=%b, need 00 0", led, step); end
  endtask

  task automatic test_rotl();
    int gap; logic [7:0] e;
    run_en = 1'b1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rotl_ready_pre: got %b need 1", cfg_ready); end
    send(3'd0, 2'd0, 8'h00);
    tests_run++;
    if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rotl_ready_load: got %b need 0", cfg_ready); end
    cyc();
    tests_run++;
    if (led !== 8'h01 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL rotl_init: led=%h ready=%b need 01 1", led, cfg_ready);
    end
    for (int i = 1; i <= 9; i++) begin e = 8'h01 << (i % 8); exp_q.push_back(e); end
    while (exp_q.size() > 0) begin
      wait_step(4 * TD, gap);
      e = exp_q.pop_front();
      tests_run++;
      if (gap != TD) begin fails++; $display("FAIL rotl_gap: got %0d need %0d", gap, TD); end
      tests_run++;
      if (led !== e) begin fails++; $display("FAIL rotl_led: got %h need %h", led, e); end
    end
  endtask

  task automatic test_bounce();
    int gap; logic [7:0] e;
    send(3'd2, 2'd1, 8'h00);
    cyc();
    tests_run++;
    if (led !== 8'h01) begin fails++; $display("FAIL bounce_init: got %h need 01", led); end
    for (int i = 1; i <= 7; i++) begin e = 8'h01 << i; exp_q.push_back(e); end
    for (int i = 6; i >= 0; i--) begin e = 8'h01 << i; exp_q.push_back(e); end
    exp_q.push_back(8'h02);
    while (exp_q.size() > 0) begin
      wait_step(4 * TD, gap);
      e = exp_q.pop_front();
      tests_run++;
      if (gap != TD / 2) begin fails++; $display("FAIL bounce_gap: got %0d need %0d", gap, TD / 2); end
      tests_run++;
      if (led !== e) begin fails++; $display("FAIL bounce_led: got %h need %h", led, e); end
    end
  endtask

  task automatic test_fill_blink();
    int gap; logic [7:0] e;
    send(3'd4, 2'd0, 8'h00);
    cyc();
    tests_run++;
    if (led !== 8'h00) begin fails++; $display("FAIL fill_init: got %h need 00", led); end
    for (int i = 1; i <= 8; i++) begin e = 8'((1 << i) - 1); exp_q.push_back(e); end
    exp_q.push_back(8'h00);
    while (exp_q.size() > 0) begin
      wait_step(4 * TD, gap);
      e = exp_q.pop_front();
      tests_run++;
      if (gap != TD || led !== e) begin
        fails++; $display("FAIL fill_step: gap=%0d led=%h need gap=%0d led=%h", gap, led, TD, e);
      end
    end
    send(3'd3, 2'd0, 8'h00);
    cyc();
    tests_run++;
    if (led !== 8'h00) begin fails++; $display("FAIL blink_init: got %h need 00", led); end
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    while (exp_q.size() > 0) begin
      wait_step(4 * TD, gap);
      e = exp_q.pop_front();
      tests_run++;
      if (gap != TD || led !== e) begin
        fails++; $display("FAIL blink_step: gap=%0d led=%h need gap=%0d led=%h", gap, led, TD, e);
      end
    end
  endtask

  task automatic test_static();
    bit bad;
    send(3'd5, 2'd0, 8'hA5);
    cyc();
    tests_run++;
    if (led !== 8'hA5) begin fails++; $display("FAIL static_init: got %h need a5", led); end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (step !== 1'b0 || led !== 8'hA5) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin fails++; $display("FAIL static_hold: led=%h step=%b need a5 0", led, step); end
  endtask

  task automatic test_pause();
    int gap; bit bad;
    send(3'd0, 2'd0, 8'h00);
    cyc();
    for (int i = 0; i < 5; i++) cyc();   // prescaler now 5
    run_en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step !== 1'b0 || led !== 8'h01) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin fails++; $display("FAIL pause_frozen: led=%h step=%b need 01 0", led, step); end
    // One cycle to re-enter RUN, then counts 5,6,7 before the tick.
    run_en = 1'b1;
    wait_step(4 * TD, gap);
    tests_run++;
    if (gap != 4) begin fails++; $display("FAIL pause_resume_gap: got %0d need 4", gap); end
    tests_run++;
    if (led !== 8'h02) begin fails++; $display("FAIL pause_resume_led: got %h need 02", led); end
  endtask

  task automatic test_reserved();
    int gap; logic [7:0] e;
    send(3'd0, 2'd0, 8'h00);
    cyc();
    for (int i = 1; i <= 4; i++) begin e = 8'h01 << i; exp_q.push_back(e); end
    while (exp_q.size() > 0) begin
      wait_step(4 * TD, gap);
      e = exp_q.pop_front();
      tests_run++;
      if (gap != TD || led !== e) begin
        fails++; $display("FAIL resv_lead: gap=%0d led=%h need gap=%0d led=%h", gap, led, TD, e);
      end
    end
    cyc(); cyc();
    send(3'd6, 2'd3, 8'h00);
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || led !== 8'h10) begin
      fails++; $display("FAIL resv_err: err=%b ready=%b led=%h need 1 1 10", cfg_err, cfg_ready, led);
    end
    cyc();
    tests_run++;
    if (cfg_err !== 1'b0) begin fails++; $display("FAIL resv_err_pulse: got %b need 0", cfg_err); end
    wait_step(4 * TD, gap);
    tests_run++;
    if (gap != 4 || led !== 8'h20) begin
      fails++; $display("FAIL resv_continue: gap=%0d led=%h need 4 20", gap, led);
    end
  endtask

  task automatic test_back_to_back();
    int gap; bit bad;
    for (int i = 0; i < TD - 1; i++) cyc();   // prescaler at P-1: tick cycle
    send(3'd1, 2'd0, 8'h00);
    tests_run++;
    if (step !== 1'b0 || led !== 8'h20 || cfg_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_tick: step=%b led=%h ready=%b need 0 20 0", step, led, cfg_ready);
    end
    cyc();
    tests_run++;
    if (led !== 8'h80 || cfg_ready !== 1'b1 || step !== 1'b0) begin
      fails++; $display("FAIL b2b_load: led=%h ready=%b step=%b need 80 1 0", led, cfg_ready, step);
    end
    wait_step(4 * TD, gap);
    tests_run++;
    if (gap != TD || led !== 8'h40) begin
      fails++; $display("FAIL b2b_rotr: gap=%0d led=%h need %0d 40", gap, led, TD);
    end
    cfg_mode = 3'd0; cfg_speed = 2'd0; cfg_valid = 1'b1; run_en = 1'b0;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    bad = (led !== 8'h01);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step !== 1'b0 || led !== 8'h01) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin fails++; $display("FAIL b2b_hold: led=%h step=%b need 01 0", led, step); end
    run_en = 1'b1;
    wait_step(4 * TD, gap);
    tests_run++;
    if (gap != TD + 1 || led !== 8'h02) begin
      fails++; $display("FAIL b2b_hold_resume: gap=%0d led=%h need %0d 02", gap, led, TD + 1);
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    cyc(); cyc();
    #3;
    sys_nrst = 1'b0;
    #1;
    tests_run++;
    if (led !== 8'h00 || cfg_ready !== 1'b1 || step !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL areset: led=%h ready=%b step=%b err=%b need 00 1 0 0", led, cfg_ready, step, cfg_err);
    end
    #2;
    sys_nrst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (led !== 8'h00 || step !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin fails++; $display("FAIL areset_idle: led=%h step=%b need 00 0", led, step); end
    send(3'd0, 2'd0, 8'h00);
    cyc();
    tests_run++;
    if (led !== 8'h01) begin fails++; $display("FAIL areset_reload: got %h need 01", led); end
  endtask

  initial begin
    sys_nrst = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_speed = '0;
    cfg_static = '0; run_en = 1'b0;
    #12;
    test_reset();
    test_rotl();
    test_bounce();
    test_fill_blink();
    test_static();
    test_pause();
    test_reserved();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
